// File: rtl/rr_arbiter_8_if.sv
// rr_arbiter_8_if: arbiter bus; req from masters, grant/grant_idx/grant_valid/hold_cnt from arbiter
interface rr_arbiter_8_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic [7:0] hold_cnt;
  modport master (output req, input grant, grant_idx, grant_valid, hold_cnt);
  modport slave  (input req, output grant, grant_idx, grant_valid, hold_cnt);
endinterface

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-way round-robin arbiter with hold limit; ports clk, rst (async high), bus (req in; grant, grant_idx, grant_valid, hold_cnt out)
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int N = 8
) (
  input logic clk,
  input logic rst,
  rr_arbiter_8_if.slave bus
);
  typedef enum logic {IDLE, GRANTED} state_t;
  state_t r_state, w_state;
  logic [2:0] r_ptr, w_ptr, r_idx, w_idx, w_pick, w_k;
  logic [7:0] r_grant, w_grant, r_cnt, w_cnt;
  logic w_release;
  // Searching from r_ptr covers both IDLE and handoff: after a grant to g, r_ptr is already g+1,
  // so the old owner is reached last and only regranted when it is the sole requester.
  always_comb begin
    w_pick = '0;
    w_k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_k = r_ptr + 3'(i);
      w_pick = bus.req[w_k] ? w_k : w_pick;
    end
    w_release = r_state == IDLE || !bus.req[r_idx] || (MAX_HOLD != 0 && r_cnt == 8'(MAX_HOLD));
    w_state = r_state;
    w_ptr = r_ptr;
    w_idx = r_idx;
    w_grant = r_grant;
    w_cnt = r_cnt;
    if (!w_release) begin
      w_cnt = r_cnt == 8'hff ? r_cnt : r_cnt + 8'd1;
    end else if (|bus.req) begin
      w_state = GRANTED;
      w_idx = w_pick;
      w_grant = 8'b1 << w_pick;
      w_ptr = w_pick + 3'd1;
      w_cnt = 8'd1;
    end else begin
      w_state = IDLE;
      w_idx = '0;
      w_grant = '0;
      w_cnt = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_idx <= '0;
      r_grant <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state;
      r_ptr <= w_ptr;
      r_idx <= w_idx;
      r_grant <= w_grant;
      r_cnt <= w_cnt;
    end
  end
  assign bus.grant = r_grant;
  assign bus.grant_idx = r_idx;
  assign bus.grant_valid = r_state == GRANTED;
  assign bus.hold_cnt = r_cnt;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: vector table, hand sequences and randomized model comparison for rr_arbiter_8
module tb_rr_arbiter_8;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int m_owner = -1;
  int m_ptr = 0;
  int m_cnt = 0;
  rr_arbiter_8_if bus ();
  rr_arbiter_8 #(.MAX_HOLD(MH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic       rst;
    logic [7:0] req;
    int         idx;
    logic       v;
    int         cnt;
  } vec_t;
  vec_t tbl[26];
  task automatic check(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  task automatic check_out(input string n, input int idx, input logic v, input int cnt);
    check({n, ".grant"}, int'(bus.grant), v ? (1 << idx) : 0);
    check({n, ".grant_idx"}, int'(bus.grant_idx), v ? idx : 0);
    check({n, ".grant_valid"}, int'(bus.grant_valid), int'(v));
    check({n, ".hold_cnt"}, int'(bus.hold_cnt), cnt);
  endtask
  // Reference: owner -1 means idle; tenure ends on dropped request or reaching the hold limit.
  task automatic model_edge(input logic [7:0] r);
    bit rel;
    rel = (m_owner < 0) || !r[m_owner] || (MH != 0 && m_cnt == MH);
    if (!rel) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    else if (r == 0) begin
      m_owner = -1;
      m_cnt = 0;
    end else begin
      for (int k = 7; k >= 0; k--)
        if (r[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
      m_ptr = (m_owner + 1) % 8;
      m_cnt = 1;
    end
  endtask
  task automatic model_reset();
    m_owner = -1;
    m_ptr = 0;
    m_cnt = 0;
  endtask
  task automatic step(input logic [7:0] r);
    bus.req = r;
    @(posedge clk);
    model_edge(r);
    #1;
  endtask
  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask
  initial begin
    logic [7:0] r;
    bus.req = '0;
    tbl[0]  = '{1'b1, 8'h00, 0, 1'b0, 0};
    tbl[1]  = '{1'b0, 8'h04, 2, 1'b1, 1};
    tbl[2]  = '{1'b1, 8'h00, 0, 1'b0, 0};
    tbl[3]  = '{1'b0, 8'h81, 0, 1'b1, 1};
    tbl[4]  = '{1'b0, 8'h80, 7, 1'b1, 1};
    tbl[5]  = '{1'b0, 8'h00, 0, 1'b0, 0};
    tbl[6]  = '{1'b0, 8'h80, 7, 1'b1, 1};
    tbl[7]  = '{1'b0, 8'h03, 0, 1'b1, 1};
    tbl[8]  = '{1'b0, 8'h82, 1, 1'b1, 1};
    tbl[9]  = '{1'b0, 8'h80, 7, 1'b1, 1};
    tbl[10] = '{1'b0, 8'h00, 0, 1'b0, 0};
    tbl[11] = '{1'b0, 8'h03, 0, 1'b1, 1};
    tbl[12] = '{1'b0, 8'h03, 0, 1'b1, 2};
    tbl[13] = '{1'b0, 8'h03, 0, 1'b1, 3};
    tbl[14] = '{1'b0, 8'h03, 0, 1'b1, 4};
    tbl[15] = '{1'b0, 8'h03, 1, 1'b1, 1};
    tbl[16] = '{1'b0, 8'h03, 1, 1'b1, 2};
    tbl[17] = '{1'b0, 8'h03, 1, 1'b1, 3};
    tbl[18] = '{1'b0, 8'h03, 1, 1'b1, 4};
    tbl[19] = '{1'b0, 8'h03, 0, 1'b1, 1};
    tbl[20] = '{1'b0, 8'h08, 3, 1'b1, 1};
    tbl[21] = '{1'b0, 8'h08, 3, 1'b1, 2};
    tbl[22] = '{1'b0, 8'h08, 3, 1'b1, 3};
    tbl[23] = '{1'b0, 8'h08, 3, 1'b1, 4};
    tbl[24] = '{1'b0, 8'h08, 3, 1'b1, 1};
    tbl[25] = '{1'b0, 8'h08, 3, 1'b1, 2};
    @(posedge clk);
    #1;
    for (int i = 0; i < 26; i++) begin
      if (tbl[i].rst) begin
        bus.req = tbl[i].req;
        pulse_reset();
      end else step(tbl[i].req);
      check_out($sformatf("vec%0d", i), tbl[i].idx, tbl[i].v, tbl[i].cnt);
    end
    pulse_reset();
    step(8'h20);
    step(8'h20);
    step(8'h20);
    check_out("pre_async_rst", 5, 1'b1, 3);
    #2;
    rst = 1'b1;
    #1;
    check_out("async_rst", 0, 1'b0, 0);
    rst = 1'b0;
    model_reset();
    step(8'h21);
    check_out("after_rst", 0, 1'b1, 1);
    r = 8'h21;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        pulse_reset();
        check_out($sformatf("rnd_rst%0d", i), 0, 1'b0, 0);
      end
      if ($urandom_range(0, 99) < 35) r = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      step(r);
      check_out($sformatf("rnd%0d", i), m_owner < 0 ? 0 : m_owner, m_owner >= 0, m_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
